fifo_sync_param: RTL and testbench

Single-clock synchronous FIFO and parametrised successor of the team's fixed 8-bit FIFO. Data width and depth are configurable. Adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a read-valid strobe, and defined simultaneous read/write behaviour at both full and empty. Used as the general buffering element between producer and consumer blocks in one clock domain.

---
 rtl/fifo_sync_param.sv | 123 ++++++++++++
 tb/tb_fifo_sync_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with almost-full/almost-empty thresholds, sticky error flags and read-valid strobe.
// Define FIFO_FWFT_EN for first-word fall-through output; the default build uses a 1-cycle registered read.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        BUFFER_IN,
  input  logic                     WR_EN,
  input  logic                     RD_EN,
  input  logic                     CLR_ERR,
  output logic [DATA_W-1:0]        BUFFER_OUT,
  output logic                     RD_VALID,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_next;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;
  logic              w_rd_acc;
  logic              w_wr_acc;

  // A write at full is only allowed when the same cycle frees a slot.
  always_comb begin
    w_rd_acc     = RD_EN && !r_empty;
    w_wr_acc     = WR_EN && (!r_full || w_rd_acc);
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_acc && !RST) begin
      r_mem[r_wr_ptr] <= BUFFER_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= (AF_THRESH == 0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_full   <= (w_count_next == C_DEPTH);
      r_afull  <= (w_count_next >= C_AF);
      r_aempty <= (w_count_next <= C_AE);
      // A new error event wins over a coincident clear.
      r_ovf    <= (WR_EN && !w_wr_acc) || (r_ovf && !CLR_ERR);
      r_udf    <= (RD_EN && !w_rd_acc) || (r_udf && !CLR_ERR);
    end
  end

`ifdef FIFO_FWFT_EN
  assign BUFFER_OUT = r_empty ? '0 : r_mem[r_rd_ptr];
  assign RD_VALID   = !r_empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_rd_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end
  end

  assign BUFFER_OUT = r_dout;
  assign RD_VALID   = r_rd_valid;
`endif

  assign EMPTY        = r_empty;
  assign FULL         = r_full;
  assign ALMOST_FULL  = r_afull;
  assign ALMOST_EMPTY = r_aempty;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;
  assign COUNT        = r_count;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (default parameters, registered-read mode).
module tb_fifo_sync_param;

  logic       clk;
  logic       rst;
  logic [7:0] buf_in;
  logic       wr_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] buf_out;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       afull;
  logic       aempty;
  logic       ovf;
  logic       udf;
  logic [3:0] count;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .CLK(clk), .RST(rst), .BUFFER_IN(buf_in), .WR_EN(wr_en), .RD_EN(rd_en),
    .CLR_ERR(clr_err), .BUFFER_OUT(buf_out), .RD_VALID(rd_valid), .EMPTY(empty),
    .FULL(full), .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty), .OVERFLOW(ovf),
    .UNDERFLOW(udf), .COUNT(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_aempty"}, 32'(aempty), 1);
    chk({tag, "_afull"}, 32'(afull), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_udf"}, 32'(udf), 0);
    chk({tag, "_rdv"}, 32'(rd_valid), 0);
    chk({tag, "_dout"}, 32'(buf_out), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_f0();
    for (int i = 0; i < 8; i++) begin
      buf_in = 8'(8'hF0 + i);
      wr_en  = 1'b1;
      tick();
      $display("write %h count=%0d", buf_in, count);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; buf_in = '0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    tick();
    check_reset_state("rst");
    rst = 1'b0;

    // Fill with F0..F7 and watch thresholds.
    for (int i = 0; i < 8; i++) begin
      buf_in = 8'(8'hF0 + i);
      wr_en  = 1'b1;
      tick();
      $display("write %h count=%0d", buf_in, count);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_aempty", 32'(aempty), (i + 1 <= 1) ? 1 : 0);
      chk("fill_afull", 32'(afull), (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 7) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
    end
    wr_en = 1'b0;

    // Write while full is rejected.
    buf_in = 8'hAA; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    $display("write AA at full count=%0d ovf=%0d", count, ovf);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_full", 32'(full), 1);
    tick();
    chk("ovf_sticky", 32'(ovf), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // Two single reads.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("read %h rdv=%0d count=%0d", buf_out, rd_valid, count);
    chk("rd1_dout", 32'(buf_out), 32'hF0);
    chk("rd1_rdv", 32'(rd_valid), 1);
    chk("rd1_count", 32'(count), 7);
    tick();
    chk("rd1_rdv_pulse", 32'(rd_valid), 0);
    chk("rd1_hold", 32'(buf_out), 32'hF0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("read %h rdv=%0d count=%0d", buf_out, rd_valid, count);
    chk("rd2_dout", 32'(buf_out), 32'hF1);
    chk("rd2_rdv", 32'(rd_valid), 1);
    chk("rd2_count", 32'(count), 6);
    chk("rd2_full", 32'(full), 0);
    tick();
    chk("rd2_rdv_pulse", 32'(rd_valid), 0);

    // Simultaneous read/write at full.
    do_reset();
    fill_f0();
    buf_in = 8'hF8; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("rw at full read %h count=%0d", buf_out, count);
    chk("rwf_dout", 32'(buf_out), 32'hF0);
    chk("rwf_count", 32'(count), 8);
    chk("rwf_full", 32'(full), 1);
    chk("rwf_ovf", 32'(ovf), 0);
    for (int k = 1; k <= 8; k++) begin
      rd_en = 1'b1;
      tick();
      $display("read %h count=%0d", buf_out, count);
      chk("drain_dout", 32'(buf_out), 32'(8'hF0 + k));
      chk("drain_count", 32'(count), 32'(8 - k));
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 1);

    // Simultaneous read/write at empty.
    tick();
    buf_in = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("rw at empty count=%0d udf=%0d rdv=%0d", count, udf, rd_valid);
    chk("rwe_count", 32'(count), 1);
    chk("rwe_udf", 32'(udf), 1);
    chk("rwe_rdv", 32'(rd_valid), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("read %h count=%0d", buf_out, count);
    chk("rwe_dout", 32'(buf_out), 32'h55);
    chk("rwe_empty", 32'(empty), 1);
    // Clear coinciding with a new underflow: set wins.
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set_wins", 32'(udf), 1);
    tick();
    clr_err = 1'b0;
    chk("udf_clr", 32'(udf), 0);

    // Streaming across pointer wrap, occupancy kept within 4..5.
    for (int i = 0; i < 4; i++) begin
      exp_w = 8'(8'h10 + i);
      buf_in = exp_w; wr_en = 1'b1;
      exp_q.push_back(exp_w);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      wr_en = (i % 3 != 2);
      rd_en = (i % 3 != 1);
      exp_w = 8'(8'h20 + i);
      buf_in = exp_w;
      tick();
      if (wr_en) exp_q.push_back(exp_w);
      if (rd_en) begin
        exp_w = exp_q.pop_front();
        $display("stream read %h count=%0d", buf_out, count);
        chk("stream_dout", 32'(buf_out), 32'(exp_w));
      end
      chk("stream_count", 32'(count), 32'(exp_q.size()));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("stream_end_count", 32'(count), 4);

    // Reset with a coincident write discards everything.
    rst = 1'b1; wr_en = 1'b1; buf_in = 8'h77;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    check_reset_state("mid_rst");
    buf_in = 8'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("read after reset %h count=%0d", buf_out, count);
    chk("post_rst_head", 32'(buf_out), 32'h99);
    chk("post_rst_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
